decoder4_16_reg: RTL and testbench
==================================

Name: decoder4_16_reg

Overview:
- Registered 4-to-16 one-hot decoder with an active-high enable.
- Used for select-line generation, e.g. digit/segment or register-file selects.
- Output is captured on the clock, which gives one cycle of latency and glitch-free selects for downstream logic.

Parameters:
- IN_W, 4, width of the binary select input. The output width is derived internally as OUT_W = 2**IN_W and is not user-settable.
- ACTIVE_LOW, 0, output polarity.
  - 0: the selected bit is 1 and all others are 0.
  - 1: the whole output vector is inverted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- d  input  IN_W  binary index to decode.
- en  input  1  decode enable, active-high.
- o  output  OUT_W  one-hot decoded select, registered.
- o_valid  output  1  registered copy of en, aligned with o.
- o_idx  output  IN_W  registered copy of d, aligned with o.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: on a rising clk edge with rst_n=0, all state is cleared. Reset has priority over everything else.
- Reset values:
  - o = all inactive: 16'h0000 when ACTIVE_LOW=0, 16'hFFFF when ACTIVE_LOW=1.
  - o_valid = 0.
  - o_idx = 0.
- Normal operation, each rising edge with rst_n=1:
  - Next value of o: if en=1, bit d is asserted and all other bits are deasserted; if en=0, all bits are deasserted. Then apply ACTIVE_LOW inversion.
  - o_valid <= en.
  - o_idx <= d.
- Latency: exactly 1 cycle from d/en to o/o_valid/o_idx. There is no combinational path from inputs to outputs.
- One-hot invariant: with en=1, exactly one bit of o is active. With en=0 or during reset, zero bits are active.
- Full index range 0..OUT_W-1 is legal with no wrap or saturation, e.g. d=4'hF maps to o[15].
- X/Z on d while en=0 must not propagate to o; the output stays all-inactive.
- Reset asserted mid-stream: the outputs go inactive on that same edge. The first valid decode appears one cycle after the first non-reset edge with en=1.
- Back-to-back index changes are decoded every cycle with no bubbles.

Decomposition:
- Shared package decode_pkg:
  - localparam DEC_IN_W = 4.
  - function onehot(idx) returning a 2**DEC_IN_W vector.
  - Reused by other select-generation blocks.
- One natural sub-module: decoder_comb, the purely combinational d/en -> one-hot function.
- The top level adds the output register stage, the polarity inversion and reset.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1, d=5 -> o=16'h0000, o_valid=0, o_idx=0 throughout.
- Disabled sweep: 5-bit counter from 0 to 15, d=count[3:0], en=count[4]=0 -> o=16'h0000 and o_valid=0 on every cycle.
- Enabled sweep: counter 16 to 31, d=0..15, en=1 -> o equals 1<<d one cycle later. Spot checks:
  - d=0 -> 16'h0001
  - d=7 -> 16'h0080
  - d=15 -> 16'h8000
  - o_valid=1 and o_idx=d in each case.
- Counter wrap: continue the enabled sweep into count=0, which gives en=0 -> the cycle after the wrap shows o=16'h0000 and o_valid=0.
- Mid-stream reset: apply en=1, d=9, then assert rst_n=0 for one cycle -> o returns to 16'h0000 on that edge. Releasing reset with en=1, d=9 held -> o=16'h0200 one cycle after release.
- Polarity: ACTIVE_LOW=1, en=1, d=3 -> o=16'hFFF7. With en=0 or during reset -> o=16'hFFFF.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared definitions for select-line generation blocks.
//            DEC_IN_W  - native binary select width (4 -> 16 selects)
//            DEC_OUT_W - derived one-hot width, 2**DEC_IN_W
//            onehot()  - binary index to one-hot vector
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

   localparam int DEC_IN_W  = 4;
   localparam int DEC_OUT_W = 2 ** DEC_IN_W;

   function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] idx);
      logic [DEC_OUT_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decoder4_16_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder4_16_reg_if
// Purpose  : Select-decoder bus bundle.
//            d, en          - binary index and enable (master -> slave)
//            o              - one-hot decoded select (slave -> master)
//            o_valid, o_idx - registered enable/index aligned with o
//            Modports: master (requester), slave (decoder).
// Revision : 1.0 - initial release
// ============================================================================
interface decoder4_16_reg_if #(
   parameter int IN_W = 4
);
   localparam int OUT_W = 2 ** IN_W;

   logic [IN_W-1:0]  d;
   logic             en;
   logic [OUT_W-1:0] o;
   logic             o_valid;
   logic [IN_W-1:0]  o_idx;

   modport master (
      output d,
      output en,
      input  o,
      input  o_valid,
      input  o_idx
   );

   modport slave (
      input  d,
      input  en,
      output o,
      output o_valid,
      output o_idx
   );

endinterface : decoder4_16_reg_if
`default_nettype wire

// File: rtl/decoder_comb.sv
`default_nettype none
// ============================================================================
// Module   : decoder_comb
// Purpose  : Purely combinational binary -> one-hot decode with enable.
//            d   [IN_W]  - binary index
//            en          - enable; 0 forces an all-zero result
//            hot [OUT_W] - active-high one-hot result
// Revision : 1.0 - initial release
// ============================================================================
module decoder_comb
   import decode_pkg::*;
#(
   parameter int IN_W  = DEC_IN_W,
   parameter int OUT_W = 2 ** IN_W
) (
   input  wire logic [IN_W-1:0]  d,
   input  wire logic             en,
   output logic      [OUT_W-1:0] hot
);

   logic [OUT_W-1:0] w_hot;

   // Native width reuses the shared helper; other widths fall back to a shift.
   generate
      if (IN_W == DEC_IN_W) begin : g_pkg
         assign w_hot = onehot(d);
      end else begin : g_shift
         assign w_hot = {{(OUT_W-1){1'b0}}, 1'b1} << d;
      end
   endgenerate

   // Enable gates the whole vector, so an unknown d with en=0 cannot leak.
   assign hot = en ? w_hot : '0;

endmodule : decoder_comb
`default_nettype wire

// File: rtl/decoder4_16_reg.sv
`default_nettype none
// ============================================================================
// Module   : decoder4_16_reg
// Purpose  : Registered 4-to-16 one-hot decoder with enable, one cycle latency.
//            clk         - system clock, rising edge
//            rst_n       - synchronous active-low reset
//            bus (slave) - d/en in; o/o_valid/o_idx out, all registered
//            IN_W        - select width (output is 2**IN_W wide)
//            ACTIVE_LOW  - 1 inverts the whole output vector
// Revision : 1.0 - initial release
// ============================================================================
module decoder4_16_reg
   import decode_pkg::*;
#(
   parameter int IN_W       = DEC_IN_W,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   decoder4_16_reg_if.slave  bus
);

   localparam int OUT_W = 2 ** IN_W;

   // Idle pattern; XOR with it applies the polarity to a decoded vector.
   localparam logic [OUT_W-1:0] c_INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   logic [OUT_W-1:0] w_hot;
   logic [OUT_W-1:0] r_o;
   logic             r_valid;
   logic [IN_W-1:0]  r_idx;

   decoder_comb #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_comb (
      .d   (bus.d),
      .en  (bus.en),
      .hot (w_hot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_o     <= c_INACTIVE;
         r_valid <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_o     <= w_hot ^ c_INACTIVE;
         r_valid <= bus.en;
         r_idx   <= bus.d;
      end
   end

   assign bus.o       = r_o;
   assign bus.o_valid = r_valid;
   assign bus.o_idx   = r_idx;

endmodule : decoder4_16_reg
`default_nettype wire

// File: tb/tb_decoder4_16_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder4_16_reg
// Purpose  : Self-checking bench for decoder4_16_reg. Drives an active-high
//            and an active-low instance from the same stimulus and compares
//            both against a behavioural model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder4_16_reg;

   localparam int IN_W  = 4;
   localparam int OUT_W = 16;

   logic            clk;
   logic            rst_n;
   logic [IN_W-1:0] d;
   logic            en;

   int n_checks;
   int n_errors;
   bit check_on;

   decoder4_16_reg_if #(.IN_W(IN_W)) bus_h ();
   decoder4_16_reg_if #(.IN_W(IN_W)) bus_l ();

   assign bus_h.d  = d;
   assign bus_h.en = en;
   assign bus_l.d  = d;
   assign bus_l.en = en;

   decoder4_16_reg #(.IN_W(IN_W), .ACTIVE_LOW(1'b0)) u_dut_h (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_h)
   );

   decoder4_16_reg #(.IN_W(IN_W), .ACTIVE_LOW(1'b1)) u_dut_l (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural decode: bit i is set exactly when enabled and i equals d.
   function automatic logic [OUT_W-1:0] model_dec(input logic e, input logic [IN_W-1:0] idx);
      logic [OUT_W-1:0] v;
      v = '0;
      if (e === 1'b1) begin
         for (int i = 0; i < OUT_W; i++) begin
            if (idx == i) v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Model state: what the outputs must show after the most recent edge.
   logic [OUT_W-1:0] m_o;
   logic             m_valid;
   logic [IN_W-1:0]  m_idx;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_o     <= '0;
         m_valid <= 1'b0;
         m_idx   <= '0;
      end else begin
         m_o     <= model_dec(en, d);
         m_valid <= en;
         m_idx   <= d;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (check_on) begin
         check("o_hi",      {16'h0, bus_h.o},        {16'h0, m_o});
         check("o_lo",      {16'h0, bus_l.o},        {16'h0, ~m_o});
         check("valid_hi",  {31'h0, bus_h.o_valid},  {31'h0, m_valid});
         check("valid_lo",  {31'h0, bus_l.o_valid},  {31'h0, m_valid});
         check("idx_hi",    {28'h0, bus_h.o_idx},    {28'h0, m_idx});
         check("idx_lo",    {28'h0, bus_l.o_idx},    {28'h0, m_idx});
      end
   end

   // Apply inputs, take one edge, settle just after it.
   task automatic step(input logic r, input logic e, input logic [IN_W-1:0] dv);
      rst_n = r;
      en    = e;
      d     = dv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] cnt;
      n_checks = 0;
      n_errors = 0;
      check_on = 1'b0;
      rst_n = 1'b0;
      en    = 1'b1;
      d     = 4'd5;
      #2;

      // Reset held for three cycles with a live request on the inputs.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 4'd5);
         check_on = 1'b1;
         check("rst_o_hi",  {16'h0, bus_h.o},       32'h0000_0000);
         check("rst_o_lo",  {16'h0, bus_l.o},       32'h0000_FFFF);
         check("rst_valid", {31'h0, bus_h.o_valid}, 32'h0);
         check("rst_idx",   {28'h0, bus_h.o_idx},   32'h0);
      end

      // 5-bit counter sweep: first half disabled, second half enabled.
      for (int c = 0; c < 32; c++) begin
         cnt = 5'(c);
         step(1'b1, cnt[4], cnt[3:0]);
         if (cnt == 5'd16) check("spot_d0",  {16'h0, bus_h.o}, 32'h0000_0001);
         if (cnt == 5'd19) check("spot_lo3", {16'h0, bus_l.o}, 32'h0000_FFF7);
         if (cnt == 5'd23) check("spot_d7",  {16'h0, bus_h.o}, 32'h0000_0080);
         if (cnt == 5'd31) begin
            check("spot_d15",   {16'h0, bus_h.o},       32'h0000_8000);
            check("spot_idx15", {28'h0, bus_h.o_idx},   32'h0000_000F);
            check("spot_val",   {31'h0, bus_h.o_valid}, 32'h1);
         end
         if (cnt == 5'd5) check("dis_o", {16'h0, bus_h.o}, 32'h0);
      end

      // Counter wraps to 0, which disables.
      step(1'b1, 1'b0, 4'd0);
      check("wrap_o",     {16'h0, bus_h.o},       32'h0);
      check("wrap_valid", {31'h0, bus_h.o_valid}, 32'h0);

      // Unknown index while disabled must not reach the selects.
      step(1'b1, 1'b0, 4'bxxxx);
      check("x_o_hi", {16'h0, bus_h.o}, 32'h0000_0000);
      check("x_o_lo", {16'h0, bus_l.o}, 32'h0000_FFFF);

      // Mid-stream reset with d=9 held.
      step(1'b1, 1'b1, 4'd9);
      check("pre_rst9", {16'h0, bus_h.o}, 32'h0000_0200);
      step(1'b0, 1'b1, 4'd9);
      check("mid_rst_o",  {16'h0, bus_h.o}, 32'h0000_0000);
      check("mid_rst_lo", {16'h0, bus_l.o}, 32'h0000_FFFF);
      step(1'b1, 1'b1, 4'd9);
      check("rel_o9", {16'h0, bus_h.o}, 32'h0000_0200);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) != 0), 1'($urandom), 4'($urandom));
      end

      @(negedge clk);
      check_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_decoder4_16_reg
`default_nettype wire
